mini_alu_seq: RTL and testbench
===============================

# mini_alu_seq

Parametrised successor of the lab mini-ALU core: a two-stage (fetch/execute) 16-instruction-class processor with a configurable data width and register-file depth, an iterative signed multiplier that stalls the pipeline, arithmetic shift right, branch-on-equal, and a HALT state. Instruction memory is external; the core drives the instruction pointer and samples the returned instruction word. It sits between the instruction ROM and the board LED/LCD outputs.

## Interface
- DATA_WIDTH, 16, register, ALU and LED-source width (16..32)
- REG_ADDR_WIDTH, 4, register-file depth = 2**REG_ADDR_WIDTH entries (2..7)
- IP_WIDTH, 16, instruction-pointer width
- Clock  in  1  single clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- oIP  out  IP_WIDTH  address presented to instruction ROM
- iInstruction  in  28  ROM data for oIP (combinational ROM, valid same cycle)
- oLed  out  8  LED register
- oLCD  out  4  LCD nibble register
- oBusy  out  1  multiplier in progress, fetch stalled
- oHalted  out  1  core stopped by HALT

## Operation
- Format: [27:24] op, [23:16] dst, [15:8] src1, [7:0] src0; immediate = [15:0].
- Register address = low REG_ADDR_WIDTH bits of a field; full field 8'hFE selects RL, 8'hFF selects RH (read-only; writes to those codes discarded).
- Opcodes: 0 NOP; 1 ADD dst=s1+s0; 2 SUB dst=s1-s0; 3 SMUL {RH,RL}=s1*s0 signed; 4 STO dst=sign-extended imm; 5 BLE if s1<=s0 (signed) IP=dst; 6 JMP IP=dst; 7 LED oLed=s1[7:0]; 8 SHL dst=s0<<s1[4:0]; 9 SHR dst=s0>>>s1[4:0] (arithmetic); 10 BEQ if s1==s0 IP=dst; 11 HALT; 12-15 behave as NOP.
- ADD/SUB/SHL/SHR wrap modulo 2**DATA_WIDTH; shift amounts >= DATA_WIDTH give 0 (SHL) or all sign bits (SHR).
- LCD: opcode 7 with dst field 8'h01 loads oLCD=s1[7:4] instead of oLed.
- Branch target zero-extended from dst[7:0] to IP_WIDTH.
- Register file: synchronous write, combinational read; a write at edge k is visible to the instruction executing in cycle k+1 (no forwarding needed).
- States: RUN, MUL, HALT. RUN->MUL on SMUL entering execute; MUL->RUN after DATA_WIDTH cycles; RUN->HALT on HALT executing; HALT exits only via Reset_n.

## Timing
- Reset (async assert, sync release): oIP=0, execute register=NOP, all registers/RL/RH=0, oLed=0, oLCD=0, oBusy=0, oHalted=0, state RUN.
- Fetch: each rising edge in RUN latches iInstruction into execute register and sets oIP=oIP+1 (wraps at 2**IP_WIDTH).
- Execute result writes at the edge ending its execute cycle; single-cycle ops: throughput 1/cycle.
- Taken branch/JMP: oIP loads target at that edge and the instruction fetched in the same cycle is squashed (execute register <- NOP); penalty 1 cycle. Not-taken: no penalty.
- SMUL: oBusy=1 for exactly DATA_WIDTH cycles starting the cycle after SMUL is latched... precisely: the cycle SMUL is in execute, oBusy rises combinationally and stays high DATA_WIDTH cycles; oIP and execute register frozen; {RH,RL} updated at the final busy edge; next instruction enters execute the following cycle. Operands sampled at first busy cycle.
- HALT: at its edge oHalted=1, oIP frozen at HALT address+1, no further writes; oBusy=0.
- Reset_n asserted mid-SMUL or in HALT: immediately returns to reset values; partial product discarded.

## Test plan
- Reset then STO r1=5, STO r2=3, ADD r3=r1+r2, LED r3 -> oLed=8'h08 four cycles after first fetch; oIP=0 during reset.
- DATA_WIDTH=16: STO r1=-3 (16'hFFFD), STO r2=7, SMUL -> oBusy high 16 cycles, then RL=16'hFFEB, RH=16'hFFFF; LED RL -> oLed=8'hEB.
- BLE with s1=2,s0=2 target 10 -> oIP=10 next edge, following fetched instruction (ADD) produces no write; with s1=3,s0=2 no branch, no bubble.
- SHR s0=16'h8000 by 4 -> 16'hF800; SHL 16'h0001 by 16 -> 0; ADD 16'h7FFF+1 -> 16'h8000.
- HALT at address 6 -> oHalted=1, oIP stays 7, oLed unchanged for 20 cycles; Reset_n pulse -> oIP=0, oHalted=0.
- Reset_n asserted in 5th SMUL busy cycle -> oBusy=0 and RL=RH=0 immediately; DATA_WIDTH=32, REG_ADDR_WIDTH=3 rerun of scenario 1 -> same oLed.

Source files
------------

// File: rtl/mini_alu_seq.sv
// Two-stage fetch/execute mini-ALU core with an iterative signed multiplier,
// branch/jump with one-cycle squash, and a HALT state left only through reset.
module mini_alu_seq #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int IP_WIDTH       = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  output logic [IP_WIDTH-1:0] oIP,
  input  logic [27:0]         iInstruction,
  output logic [7:0]          oLed,
  output logic [3:0]          oLCD,
  output logic                oBusy,
  output logic                oHalted
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CW    = $clog2(DATA_WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SMUL = 4'd3;
  localparam logic [3:0] OP_STO  = 4'd4;
  localparam logic [3:0] OP_BLE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_LED  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;

  typedef enum logic [1:0] {RUN = 2'd0, MUL = 2'd1, HALT = 2'd2} state_e;

  state_e                 state_q;
  logic [27:0]            instr_q;
  logic [IP_WIDTH-1:0]    ip_q;
  logic [DATA_WIDTH-1:0]  regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]  rl_q, rh_q;
  logic [7:0]             led_q;
  logic [3:0]             lcd_q;
  logic                   halted_q;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          acc_q, mcand_q;
  logic [DATA_WIDTH-1:0]  mplier_q;

  logic [3:0]             op;
  logic [7:0]             dstF, src1F, src0F;
  logic signed [15:0]     imm;
  logic [DATA_WIDTH-1:0]  src1, src0, wrData;
  logic                   wrEn, taken, dstWritable, lastStep;
  logic [IP_WIDTH-1:0]    target;
  logic [PW-1:0]          mcandInit, addend, acc_d;

  assign op          = instr_q[27:24];
  assign dstF        = instr_q[23:16];
  assign src1F       = instr_q[15:8];
  assign src0F       = instr_q[7:0];
  assign imm         = instr_q[15:0];
  assign target      = IP_WIDTH'(dstF);
  assign dstWritable = (dstF[7:1] != 7'h7F);

  // Codes FE/FF read the multiplier result halves instead of the register file.
  always_comb begin
    src1 = regs_q[src1F[REG_ADDR_WIDTH-1:0]];
    if (src1F == 8'hFE)      src1 = rl_q;
    else if (src1F == 8'hFF) src1 = rh_q;
    src0 = regs_q[src0F[REG_ADDR_WIDTH-1:0]];
    if (src0F == 8'hFE)      src0 = rl_q;
    else if (src0F == 8'hFF) src0 = rh_q;
  end

  always_comb begin
    wrEn   = 1'b0;
    wrData = '0;
    taken  = 1'b0;
    case (op)
      OP_ADD: begin wrEn = 1'b1; wrData = src1 + src0; end
      OP_SUB: begin wrEn = 1'b1; wrData = src1 - src0; end
      OP_STO: begin wrEn = 1'b1; wrData = DATA_WIDTH'(imm); end
      OP_SHL: begin wrEn = 1'b1; wrData = src0 << src1[4:0]; end
      OP_SHR: begin wrEn = 1'b1; wrData = $signed(src0) >>> src1[4:0]; end
      OP_BLE: taken = ($signed(src1) <= $signed(src0));
      OP_JMP: taken = 1'b1;
      OP_BEQ: taken = (src1 == src0);
      default: ;
    endcase
  end

  // Shift-add over the multiplier bits; the MSB carries negative weight.
  assign mcandInit = PW'($signed(src1));
  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign lastStep  = (cnt_q == CW'(DATA_WIDTH - 1));
  assign acc_d     = lastStep ? (acc_q - addend) : (acc_q + addend);

  assign oBusy   = (state_q == MUL) || ((state_q == RUN) && (op == OP_SMUL));
  assign oIP     = ip_q;
  assign oLed    = led_q;
  assign oLCD    = lcd_q;
  assign oHalted = halted_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= RUN;
      instr_q  <= '0;
      ip_q     <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rl_q     <= '0;
      rh_q     <= '0;
      led_q    <= '0;
      lcd_q    <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (op == OP_SMUL) begin
            acc_q    <= src0[0] ? mcandInit : '0;
            mcand_q  <= mcandInit << 1;
            mplier_q <= src0 >> 1;
            cnt_q    <= CW'(1);
            state_q  <= MUL;
          end else if (op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            if (wrEn && dstWritable) regs_q[dstF[REG_ADDR_WIDTH-1:0]] <= wrData;
            if (op == OP_LED) begin
              if (dstF == 8'h01) lcd_q <= src1[7:4];
              else               led_q <= src1[7:0];
            end
            if (taken) begin
              ip_q    <= target;
              instr_q <= '0;
            end else begin
              ip_q    <= ip_q + IP_WIDTH'(1);
              instr_q <= iInstruction;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (lastStep) begin
            rl_q    <= acc_d[DATA_WIDTH-1:0];
            rh_q    <= acc_d[PW-1:DATA_WIDTH];
            ip_q    <= ip_q + IP_WIDTH'(1);
            instr_q <= iInstruction;
            state_q <= RUN;
          end
        end
        HALT: ;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_seq.sv
// Directed bench for mini_alu_seq: default 16-bit core plus a 32-bit/8-register
// instance running the basic add-and-display program.
module tb_mini_alu_seq;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [15:0] ipA, ipB;
  logic [27:0] instrA, instrB;
  logic [7:0]  ledA, ledB;
  logic [3:0]  lcdA, lcdB;
  logic        busyA, busyB, haltedA, haltedB;
  logic [27:0] romA [64];
  logic [27:0] romB [64];
  int          checks = 0;
  int          errors = 0;

  always #5 Clock = ~Clock;

  assign instrA = romA[ipA[5:0]];
  assign instrB = romB[ipB[5:0]];

  mini_alu_seq dutA (
    .Clock(Clock), .Reset_n(Reset_n), .oIP(ipA), .iInstruction(instrA),
    .oLed(ledA), .oLCD(lcdA), .oBusy(busyA), .oHalted(haltedA)
  );

  mini_alu_seq #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(3), .IP_WIDTH(16)) dutB (
    .Clock(Clock), .Reset_n(Reset_n), .oIP(ipB), .iInstruction(instrB),
    .oLed(ledB), .oLCD(lcdB), .oBusy(busyB), .oHalted(haltedB)
  );

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {4'd4, d, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge Clock);
  endtask

  task automatic clearRomA;
    for (int i = 0; i < 64; i++) romA[i] = '0;
  endtask

  initial begin
    Reset_n = 1'b0;
    clearRomA();
    for (int i = 0; i < 64; i++) romB[i] = '0;

    // Add two stored values, show the sum on the LEDs and a nibble on the LCD.
    romA[0] = sto(8'd1, 16'd5);
    romA[1] = sto(8'd2, 16'd3);
    romA[2] = ins(4'd1, 8'd3, 8'd1, 8'd2);
    romA[3] = ins(4'd7, 8'd0, 8'd3, 8'd0);
    romA[4] = sto(8'd4, 16'h00A0);
    romA[5] = ins(4'd7, 8'd1, 8'd4, 8'd0);
    for (int i = 0; i < 4; i++) romB[i] = romA[i];
    romB[4] = ins(4'd11, 8'd0, 8'd0, 8'd0);
    applyStimulus(2);
    checkOutput("reset_ip", 32'(ipA), 32'h0);
    checkOutput("reset_led", 32'(ledA), 32'h0);
    checkOutput("reset_lcd", 32'(lcdA), 32'h0);
    checkOutput("reset_busy", 32'(busyA), 32'h0);
    checkOutput("reset_halted", 32'(haltedA), 32'h0);
    Reset_n = 1'b1;
    applyStimulus(4);
    checkOutput("s1_led_early", 32'(ledA), 32'h0);
    applyStimulus(1);
    checkOutput("s1_led_sum", 32'(ledA), 32'h08);
    checkOutput("s1_ip", 32'(ipA), 32'h5);
    checkOutput("s1_w32_led_sum", 32'(ledB), 32'h08);
    applyStimulus(2);
    checkOutput("s1_lcd", 32'(lcdA), 32'hA);
    checkOutput("s1_led_kept", 32'(ledA), 32'h08);
    checkOutput("s1_w32_halted", 32'(haltedB), 32'h1);
    checkOutput("s1_w32_busy", 32'(busyB), 32'h0);
    checkOutput("s1_w32_lcd", 32'(lcdB), 32'h0);

    // Signed multiply -3 * 7 with a 16-cycle stall.
    Reset_n = 1'b0;
    clearRomA();
    romA[0] = sto(8'd1, 16'hFFFD);
    romA[1] = sto(8'd2, 16'd7);
    romA[2] = ins(4'd3, 8'd0, 8'd1, 8'd2);
    romA[3] = ins(4'd7, 8'd0, 8'hFE, 8'd0);
    romA[4] = ins(4'd7, 8'd0, 8'hFF, 8'd0);
    applyStimulus(2);
    Reset_n = 1'b1;
    applyStimulus(2);
    checkOutput("mul_busy_before", 32'(busyA), 32'h0);
    applyStimulus(1);
    checkOutput("mul_busy_first", 32'(busyA), 32'h1);
    checkOutput("mul_ip_first", 32'(ipA), 32'h3);
    applyStimulus(8);
    checkOutput("mul_ip_frozen", 32'(ipA), 32'h3);
    applyStimulus(7);
    checkOutput("mul_busy_last", 32'(busyA), 32'h1);
    applyStimulus(1);
    checkOutput("mul_busy_done", 32'(busyA), 32'h0);
    checkOutput("mul_ip_resume", 32'(ipA), 32'h4);
    applyStimulus(1);
    checkOutput("mul_rl_led", 32'(ledA), 32'hEB);
    applyStimulus(1);
    checkOutput("mul_rh_led", 32'(ledA), 32'hFF);

    // Taken BLE/BEQ/JMP squash the next fetch; a not-taken BLE costs nothing.
    Reset_n = 1'b0;
    clearRomA();
    romA[0]  = sto(8'd1, 16'd2);
    romA[1]  = sto(8'd2, 16'd2);
    romA[2]  = sto(8'd3, 16'd3);
    romA[3]  = ins(4'd5, 8'd10, 8'd1, 8'd2);
    romA[4]  = ins(4'd1, 8'd4, 8'd1, 8'd2);
    romA[10] = ins(4'd7, 8'd0, 8'd4, 8'd0);
    romA[11] = ins(4'd5, 8'd20, 8'd3, 8'd2);
    romA[12] = ins(4'd7, 8'd0, 8'd3, 8'd0);
    romA[13] = ins(4'd10, 8'd30, 8'd1, 8'd2);
    romA[14] = sto(8'd5, 16'h0055);
    romA[30] = ins(4'd7, 8'd0, 8'd5, 8'd0);
    romA[31] = ins(4'd6, 8'd40, 8'd0, 8'd0);
    romA[32] = sto(8'd5, 16'h0066);
    romA[40] = ins(4'd1, 8'd6, 8'd5, 8'd1);
    romA[41] = ins(4'd7, 8'd0, 8'd6, 8'd0);
    applyStimulus(2);
    Reset_n = 1'b1;
    applyStimulus(5);
    checkOutput("ble_taken_ip", 32'(ipA), 32'd10);
    applyStimulus(2);
    checkOutput("ble_squash_led", 32'(ledA), 32'h00);
    applyStimulus(1);
    checkOutput("ble_not_taken_ip", 32'(ipA), 32'd13);
    applyStimulus(1);
    checkOutput("ble_not_taken_led", 32'(ledA), 32'h03);
    applyStimulus(1);
    checkOutput("beq_taken_ip", 32'(ipA), 32'd30);
    applyStimulus(2);
    checkOutput("beq_squash_led", 32'(ledA), 32'h00);
    applyStimulus(1);
    checkOutput("jmp_ip", 32'(ipA), 32'd40);
    applyStimulus(3);
    checkOutput("jmp_squash_led", 32'(ledA), 32'h02);

    // Shift and wraparound corner cases.
    Reset_n = 1'b0;
    clearRomA();
    romA[0]  = sto(8'd1, 16'h8000);
    romA[1]  = sto(8'd2, 16'd4);
    romA[2]  = ins(4'd9, 8'd3, 8'd2, 8'd1);
    romA[3]  = sto(8'd4, 16'd8);
    romA[4]  = ins(4'd9, 8'd5, 8'd4, 8'd3);
    romA[5]  = ins(4'd7, 8'd0, 8'd3, 8'd0);
    romA[6]  = ins(4'd7, 8'd0, 8'd5, 8'd0);
    romA[7]  = sto(8'd6, 16'd1);
    romA[8]  = sto(8'd7, 16'd16);
    romA[9]  = ins(4'd8, 8'd8, 8'd7, 8'd6);
    romA[10] = ins(4'd7, 8'd0, 8'd8, 8'd0);
    romA[11] = sto(8'd9, 16'h7FFF);
    romA[12] = ins(4'd1, 8'd10, 8'd9, 8'd6);
    romA[13] = ins(4'd9, 8'd11, 8'd4, 8'd10);
    romA[14] = ins(4'd7, 8'd0, 8'd11, 8'd0);
    romA[15] = ins(4'd9, 8'd12, 8'd7, 8'd10);
    romA[16] = ins(4'd7, 8'd0, 8'd12, 8'd0);
    applyStimulus(2);
    Reset_n = 1'b1;
    applyStimulus(7);
    checkOutput("shr4_low", 32'(ledA), 32'h00);
    applyStimulus(1);
    checkOutput("shr4_high", 32'(ledA), 32'hF8);
    applyStimulus(4);
    checkOutput("shl16", 32'(ledA), 32'h00);
    applyStimulus(4);
    checkOutput("add_wrap", 32'(ledA), 32'h80);
    applyStimulus(2);
    checkOutput("shr16", 32'(ledA), 32'hFF);

    // HALT at address 6 freezes the core until reset.
    Reset_n = 1'b0;
    clearRomA();
    romA[0] = sto(8'd1, 16'h005A);
    romA[1] = ins(4'd7, 8'd0, 8'd1, 8'd0);
    romA[6] = ins(4'd11, 8'd0, 8'd0, 8'd0);
    romA[7] = ins(4'd7, 8'd0, 8'd2, 8'd0);
    romA[8] = ins(4'd7, 8'd0, 8'd2, 8'd0);
    applyStimulus(2);
    Reset_n = 1'b1;
    applyStimulus(7);
    checkOutput("halt_pre_flag", 32'(haltedA), 32'h0);
    checkOutput("halt_pre_ip", 32'(ipA), 32'd7);
    applyStimulus(1);
    checkOutput("halt_flag", 32'(haltedA), 32'h1);
    checkOutput("halt_ip", 32'(ipA), 32'd7);
    checkOutput("halt_busy", 32'(busyA), 32'h0);
    applyStimulus(20);
    checkOutput("halt_ip_held", 32'(ipA), 32'd7);
    checkOutput("halt_flag_held", 32'(haltedA), 32'h1);
    checkOutput("halt_led_held", 32'(ledA), 32'h5A);
    Reset_n = 1'b0;
    #1;
    checkOutput("halt_reset_ip", 32'(ipA), 32'h0);
    checkOutput("halt_reset_flag", 32'(haltedA), 32'h0);

    // Reset in the fifth busy cycle of a second multiply clears RL/RH.
    applyStimulus(1);
    clearRomA();
    romA[0] = sto(8'd1, 16'hFFFD);
    romA[1] = sto(8'd2, 16'd7);
    romA[2] = ins(4'd3, 8'd0, 8'd1, 8'd2);
    romA[3] = ins(4'd3, 8'd0, 8'd1, 8'd2);
    Reset_n = 1'b1;
    applyStimulus(23);
    checkOutput("mulrst_busy_before", 32'(busyA), 32'h1);
    checkOutput("mulrst_ip_before", 32'(ipA), 32'd4);
    Reset_n = 1'b0;
    #1;
    checkOutput("mulrst_busy", 32'(busyA), 32'h0);
    checkOutput("mulrst_ip", 32'(ipA), 32'h0);
    clearRomA();
    romA[0] = ins(4'd7, 8'd0, 8'hFE, 8'd0);
    romA[1] = ins(4'd7, 8'd1, 8'hFF, 8'd0);
    applyStimulus(2);
    Reset_n = 1'b1;
    applyStimulus(2);
    checkOutput("mulrst_rl", 32'(ledA), 32'h00);
    applyStimulus(1);
    checkOutput("mulrst_rh", 32'(lcdA), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
